// File: rtl/instr_fetch_stage.sv
// Purpose: RV32IM fetch stage; owns the PC, drives the imem request/busywait handshake, fills IF/ID.
// Latency: one cycle from an accepted fetch to IF/ID; zero-wait memory sustains one instruction per cycle.
// Backpressure: imem_busywait and stall_id hold the PC; stall_id also holds IF/ID, a busywait-only cycle inserts a bubble.
//
// Ports:
//   CLK, RESET                       rising-edge clock, asynchronous active-high reset
//   imem_addr/imem_read              fetch address (the PC) and request, decoded from registered state
//   imem_rdata/imem_busywait         returned word, valid when imem_read=1 and imem_busywait=0
//   stall_id                         decode hazard: hold PC and IF/ID
//   branch_taken/branch_target       redirect from EX; target bits [1:0] are ignored
//   if_id_pc/pc4/instr/valid         IF/ID pipeline register
//   perf_fetch_cnt/perf_stall_cnt    present only when IF_PERF_COUNTERS_EN is defined
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busywait,
    input  logic        stall_id,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic        accept;
    logic        ifid_ld;
    logic        ifid_bubble;
    logic [31:0] tgt_aligned;
    logic [31:0] pc_plus4;

    // Request is a pure decode of state so that an asynchronous reset
    // withdraws it immediately.
    assign imem_read   = (state_q != BOOT);
    assign imem_addr   = pc_q;
    assign accept      = imem_read && !imem_busywait;
    assign tgt_aligned = branch_target & 32'hFFFF_FFFC;
    assign pc_plus4    = pc_q + 32'd4;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        ifid_ld     = 1'b0;
        ifid_bubble = 1'b0;

        // IF/ID policy: a redirect always flushes, a decode stall holds,
        // otherwise load a real word only on an accept that is not being
        // discarded (DROP), else insert a bubble.
        if (branch_taken) begin
            ifid_bubble = 1'b1;
        end else if (stall_id) begin
            ifid_bubble = 1'b0;
        end else if (accept && (state_q != DROP)) begin
            ifid_ld = 1'b1;
        end else begin
            ifid_bubble = 1'b1;
        end

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH, WAIT: begin
                if (accept) begin
                    state_d = FETCH;
                    if (branch_taken) begin
                        pc_d = tgt_aligned;
                    end else if (!stall_id) begin
                        pc_d = pc_plus4;
                    end
                end else if (branch_taken) begin
                    // The in-flight access cannot be cancelled; remember the
                    // target and throw the returning word away.
                    redir_d = tgt_aligned;
                    state_d = DROP;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (accept) begin
                    // A redirect arriving on the same edge is the newest one.
                    pc_d    = branch_taken ? tgt_aligned : redir_q;
                    state_d = FETCH;
                end else if (branch_taken) begin
                    redir_d = tgt_aligned;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q        <= RESET_PC;
            redir_q     <= RESET_PC;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            redir_q <= redir_d;
            if (ifid_ld) begin
                if_id_pc    <= pc_q;
                if_id_pc4   <= pc_plus4;
                if_id_instr <= imem_rdata;
                if_id_valid <= 1'b1;
            end else if (ifid_bubble) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (ifid_ld) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if ((imem_read && imem_busywait) || stall_id) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Purpose: scoreboard bench for instr_fetch_stage with a transaction-level reference model.
// Latency: model pushes one IF/ID expectation per clock edge; monitor pops on the following falling edge.
// Backpressure: memory busywait, decode stall and redirects are driven randomly plus directed scenarios.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic        stall_id;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .imem_addr     (imem_addr),
        .imem_read     (imem_read),
        .imem_rdata    (imem_rdata),
        .imem_busywait (imem_busywait),
        .stall_id      (stall_id),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory: the word at address A is A|0x13; garbage while busy.
    assign imem_rdata = imem_busywait ? 32'hBAD0_BAD0 : (imem_addr | 32'h13);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    ifid_t       exp_q[$];
    ifid_t       last_exp;
    int          errors = 0;
    int          checks = 0;

    // Reference model: architectural fetch pointer plus an optional pending redirect.
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    bit          m_read;
    bit          m_pend;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          acc;
        logic [31:0] tgt;
        ifid_t       nx;
        acc = m_read && !imem_busywait;
        tgt = branch_target & 32'hFFFF_FFFC;
        nx  = last_exp;
        if ((m_read && imem_busywait) || stall_id) m_stall = m_stall + 1;
        if (branch_taken) begin
            nx.valid = 1'b0;
            nx.instr = NOP;
        end else if (stall_id) begin
            nx = last_exp;
        end else if (acc && !m_pend) begin
            nx = '{valid: 1'b1, pc: m_pc, instr: m_pc | 32'h13};
            m_fetch = m_fetch + 1;
        end else begin
            nx.valid = 1'b0;
            nx.instr = NOP;
        end
        exp_q.push_back(nx);
        last_exp = nx;
        if (m_read) begin
            if (m_pend) begin
                if (acc) begin
                    m_pc   = branch_taken ? tgt : m_redir;
                    m_pend = 1'b0;
                end else if (branch_taken) begin
                    m_redir = tgt;
                end
            end else if (acc) begin
                if (branch_taken) m_pc = tgt;
                else if (!stall_id) m_pc = m_pc + 32'd4;
            end else if (branch_taken) begin
                m_pend  = 1'b1;
                m_redir = tgt;
            end
        end
        m_read = 1'b1;
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_pc     = 32'd0;
            m_redir  = 32'd0;
            m_read   = 1'b0;
            m_pend   = 1'b0;
            m_fetch  = 32'd0;
            m_stall  = 32'd0;
            last_exp = '{valid: 1'b0, pc: 32'd0, instr: NOP};
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // Monitor: compares the DUT against the model away from the active edge.
    always @(negedge CLK) begin
        ifid_t e;
        if (RESET !== 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : last_exp;
            chk("imem_read", {31'd0, imem_read}, {31'd0, m_read});
            chk("imem_addr", imem_addr, m_pc);
            chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
            chk("if_id_instr", if_id_instr, e.instr);
            if (e.valid) begin
                chk("if_id_pc", if_id_pc, e.pc);
                chk("if_id_pc4", if_id_pc4, e.pc + 32'd4);
            end
`ifdef IF_PERF_COUNTERS_EN
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
            chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
        end
    end

    task automatic cyc(input bit b, input bit s, input bit br, input logic [31:0] t);
        imem_busywait = b;
        stall_id      = s;
        branch_taken  = br;
        branch_target = t;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cyc(0, 0, 0, 32'd0);
        chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_if_id_pc", if_id_pc, 32'd0);
        chk("rst_if_id_pc4", if_id_pc4, 32'd0);
        chk("rst_if_id_instr", if_id_instr, NOP);
        chk("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
`ifdef IF_PERF_COUNTERS_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        RESET = 1'b0;
        cyc(0, 0, 0, 32'd0);  // BOOT edge
        chk("first_request", {31'd0, imem_read}, 32'd1);
    endtask

    initial begin
        RESET         = 1'b1;
        imem_busywait = 1'b0;
        stall_id      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        @(posedge CLK);
        #1;
        do_reset();

        // Zero-wait stream, then busywait 3 cycles on 0x8.
        cyc(0, 0, 0, 32'd0);
        cyc(0, 0, 0, 32'd0);
        chk("stream_addr", imem_addr, 32'h8);
        chk("stream_pc4", if_id_pc4, 32'h8);
        repeat (3) cyc(1, 0, 0, 32'd0);
        chk("busy_hold_addr", imem_addr, 32'h8);
        chk("busy_bubble", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 0, 32'd0);
        chk("busy_release_pc", if_id_pc, 32'h8);
        cyc(0, 0, 0, 32'd0);
        // Decode stall at 0x10.
        repeat (2) cyc(0, 1, 0, 32'd0);
        chk("stall_addr", imem_addr, 32'h10);
        chk("stall_hold_pc", if_id_pc, 32'hC);
        cyc(0, 0, 0, 32'd0);
        chk("stall_refetch", if_id_instr, 32'h13);
        // Redirect during WAIT, drained through DROP.
        cyc(1, 0, 0, 32'd0);
        cyc(1, 0, 1, 32'h103);
        repeat (2) cyc(1, 0, 0, 32'd0);
        cyc(0, 0, 0, 32'd0);
        chk("drop_redirect", imem_addr, 32'h100);
        chk("drop_discard", {31'd0, if_id_valid}, 32'd0);
        // Redirect beats stall, and PC wrap.
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        chk("br_addr", imem_addr, 32'hFFFF_FFFC);
        chk("br_flush", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 1, 1, 32'h40);
        chk("br_over_stall", imem_addr, 32'h40);
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 32'd0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);

        // Reset mid-access drops the request at once.
        cyc(1, 0, 0, 32'd0);
        #1 RESET = 1'b1;
        #1;
        chk("async_rst_read", {31'd0, imem_read}, 32'd0);
        chk("async_rst_valid", {31'd0, if_id_valid}, 32'd0);
        @(posedge CLK);
        #1;
        do_reset();

`ifdef IF_PERF_COUNTERS_EN
        cyc(0, 0, 0, 32'd0);
        cyc(0, 0, 0, 32'd0);
        cyc(1, 0, 0, 32'd0);
        cyc(1, 0, 0, 32'd0);
        repeat (3) cyc(0, 0, 0, 32'd0);
        chk("perf_fetch5", perf_fetch_cnt, 32'd5);
        chk("perf_stall2", perf_stall_cnt, 32'd2);
        do_reset();
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                $urandom_range(0, 9) == 0, $urandom);
        end
        cyc(0, 0, 0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
